// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: holds one instruction from EXE, issues stores
// to the data SRAM over req/addr_ok, and exports rf / store-data bypass bundles.
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    // EXE -> MEM pipeline input
    input  logic        es_to_ms_valid,
    input  logic [31:0] es_pc,
    input  logic [31:0] es_sram_addr,
    input  logic [31:0] es_sram_wdata,
    input  logic [31:0] es_rf_wdata,
    input  logic [3:0]  es_rf_we,
    input  logic [4:0]  es_rf_waddr,
    input  logic [3:0]  es_mem_op,
    // MEM -> WB
    input  logic        ws_allow_in,
    output logic        ms_allow_in,
    output logic        ms_to_ws_valid,
    output logic        ms_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_rf_wdata,
    output logic [3:0]  ms_rf_we,
    output logic [4:0]  ms_rf_waddr,
    output logic        ms_ale,
    // data SRAM write port
    output logic        data_sram_req,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    // store-data bypass to EXE load forwarding
    output logic [3:0]  ms_sram_we,
    output logic [31:0] ms_sram_addr,
    output logic [31:0] ms_sram_wdata,
    // store FSM state: 0 = IDLE, 1 = DONE
    output logic        dbg_state
);

    // Handshakes: a transfer happens on a cycle where valid and the receiver's
    // ready (allow_in / addr_ok) are both high at the rising edge of clk.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] ms_addr_raw;
    logic [31:0] ms_st_data;
    logic [3:0]  ms_mem_op;
    logic [3:0]  ms_rf_we_r;

    logic        is_store;
    logic        misaligned;
    logic        ms_ready_go;
    logic        ms_leave;
    logic [1:0]  lane;
    logic [3:0]  wstrb;
    logic [31:0] wdata;

    assign lane     = ms_addr_raw[1:0];
    assign is_store = (ms_mem_op[3:2] == 2'b00) && (ms_mem_op[1:0] != 2'b00);

    always_comb begin
        wstrb      = 4'b0000;
        wdata      = ms_st_data;
        misaligned = 1'b0;
        case (ms_mem_op)
            4'b0001: begin
                wstrb = 4'b0001 << lane;
                wdata = {4{ms_st_data[7:0]}};
            end
            4'b0010: begin
                wstrb      = lane[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{ms_st_data[15:0]}};
                misaligned = lane[0];
            end
            4'b0011: begin
                wstrb      = 4'b1111;
                misaligned = (lane != 2'b00);
            end
            default: ;
        endcase
    end

    assign ms_ale         = ms_valid && misaligned;
    assign data_sram_req  = ms_valid && is_store && !misaligned && (state == S_IDLE);
    assign ms_ready_go    = !is_store || misaligned || (state == S_DONE)
                          || (data_sram_req && data_sram_addr_ok);
    assign ms_allow_in    = !ms_valid || (ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign ms_leave       = ms_to_ws_valid && ws_allow_in;

    assign ms_rf_we        = (ms_valid && !ms_ale) ? ms_rf_we_r : 4'b0000;
    assign data_sram_wstrb = wstrb;
    assign data_sram_addr  = {ms_addr_raw[31:2], 2'b00};
    assign data_sram_wdata = wdata;
    assign ms_sram_we      = ms_valid ? wstrb : 4'b0000;
    assign ms_sram_addr    = data_sram_addr;
    assign ms_sram_wdata   = data_sram_wdata;
    assign dbg_state       = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid    <= 1'b0;
            state       <= S_IDLE;
            ms_pc       <= RESET_PC;
            ms_addr_raw <= 32'h0;
            ms_st_data  <= 32'h0;
            ms_rf_wdata <= 32'h0;
            ms_rf_we_r  <= 4'h0;
            ms_rf_waddr <= 5'h0;
            ms_mem_op   <= 4'h0;
        end else begin
            if (ms_allow_in) begin
                ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allow_in) begin
                ms_pc       <= es_pc;
                ms_addr_raw <= es_sram_addr;
                ms_st_data  <= es_sram_wdata;
                ms_rf_wdata <= es_rf_wdata;
                ms_rf_we_r  <= es_rf_we;
                ms_rf_waddr <= es_rf_waddr;
                ms_mem_op   <= es_mem_op;
            end
            // DONE remembers an accepted store while WB stalls, so it is never re-issued
            case (state)
                S_IDLE: if (data_sram_req && data_sram_addr_ok && !ws_allow_in) state <= S_DONE;
                S_DONE: if (ms_leave) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
